// File: rtl/debouncer_pkg.sv
// Shared defaults, legal parameter ranges and counter sizing for the multi-channel switch debouncer.
// Long-press support is compiled in only when DEBOUNCER_LONG_PRESS_EN is defined.
package debouncer_pkg;

    localparam int unsigned N_CH_DEF   = 4;
    localparam int unsigned STABLE_DEF = 16;
    localparam int unsigned SYNC_DEF   = 2;
    localparam int unsigned LONG_DEF   = 1024;

    localparam int unsigned N_CH_MIN   = 1;
    localparam int unsigned N_CH_MAX   = 32;
    localparam int unsigned STABLE_MIN = 2;
    localparam int unsigned STABLE_MAX = 65535;
    localparam int unsigned SYNC_MIN   = 2;
    localparam int unsigned SYNC_MAX   = 4;

    // Counter that must reach terminal-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned terminal);
        return (terminal < 2) ? 1 : $clog2(terminal);
    endfunction

endpackage

// File: rtl/debouncer_ch.sv
// One debounce channel: sync chain, stability counter, edge pulses, long-press when DEBOUNCER_LONG_PRESS_EN.
// Latency SYNC_STAGES+STABLE_CYCLES cycles with en_i high; no backpressure, en_i only gates counting.
module debouncer_ch
    import debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_DEF,
    parameter int unsigned SYNC_STAGES   = SYNC_DEF
`ifdef DEBOUNCER_LONG_PRESS_EN
    ,
    parameter int unsigned LONG_CYCLES   = LONG_DEF
`endif
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic sw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
`ifdef DEBOUNCER_LONG_PRESS_EN
    ,
    output logic long_o
`endif
);

    localparam int unsigned   CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // A disagreement must persist for STABLE_CYCLES enabled samples; any agreement restarts it.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sw_i};
        cnt_d  = cnt_q;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync_lvl == db_q) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                db_d   = sync_lvl;
                rise_d = sync_lvl;
                fall_d = ~sync_lvl;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

`ifdef DEBOUNCER_LONG_PRESS_EN
    localparam int unsigned   LW        = cnt_width(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          ldone_q, ldone_d;
    logic          long_q, long_d;

    // Counter parks at LONG_LAST after the pulse; ldone_q keeps it from firing again until release.
    always_comb begin
        lcnt_d  = lcnt_q;
        ldone_d = ldone_q;
        long_d  = 1'b0;
        if (!db_q) begin
            lcnt_d  = '0;
            ldone_d = 1'b0;
        end else if (en_i && !ldone_q) begin
            if (lcnt_q == LONG_LAST) begin
                long_d  = 1'b1;
                ldone_d = 1'b1;
            end else begin
                lcnt_d = lcnt_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lcnt_q  <= '0;
            ldone_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            lcnt_q  <= lcnt_d;
            ldone_q <= ldone_d;
            long_q  <= long_d;
        end
    end

    assign long_o = long_q;
`endif

`ifndef SYNTHESIS
    a_no_dual_pulse: assert property (@(posedge clk_i) disable iff (rst_i) !(rise_q && fall_q));
    a_cnt_bound:     assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= CNT_LAST);
`endif

endmodule

// File: rtl/debouncer_multi.sv
// N_CH independent switch debouncers sharing one sample enable; long-press outputs with DEBOUNCER_LONG_PRESS_EN.
// Latency SYNC_STAGES+STABLE_CYCLES cycles with en_i high; no backpressure, en_i only gates counting.
module debouncer_multi
    import debouncer_pkg::*;
#(
    parameter int unsigned N_CH          = N_CH_DEF,
    parameter int unsigned STABLE_CYCLES = STABLE_DEF,
    parameter int unsigned SYNC_STAGES   = SYNC_DEF
`ifdef DEBOUNCER_LONG_PRESS_EN
    ,
    parameter int unsigned LONG_CYCLES   = LONG_DEF
`endif
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [N_CH-1:0] sw_i,
    output logic [N_CH-1:0] db_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o
`ifdef DEBOUNCER_LONG_PRESS_EN
    ,
    output logic [N_CH-1:0] long_o
`endif
);

    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_n_ch
        $fatal(1, "debouncer_multi: N_CH=%0d outside %0d..%0d", N_CH, N_CH_MIN, N_CH_MAX);
    end
    if (STABLE_CYCLES < STABLE_MIN || STABLE_CYCLES > STABLE_MAX) begin : g_bad_stable
        $fatal(1, "debouncer_multi: STABLE_CYCLES=%0d outside %0d..%0d",
               STABLE_CYCLES, STABLE_MIN, STABLE_MAX);
    end
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $fatal(1, "debouncer_multi: SYNC_STAGES=%0d outside %0d..%0d", SYNC_STAGES, SYNC_MIN, SYNC_MAX);
    end
`ifdef DEBOUNCER_LONG_PRESS_EN
    if (LONG_CYCLES <= STABLE_CYCLES) begin : g_bad_long
        $fatal(1, "debouncer_multi: LONG_CYCLES=%0d must exceed STABLE_CYCLES=%0d",
               LONG_CYCLES, STABLE_CYCLES);
    end
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debouncer_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES)
`ifdef DEBOUNCER_LONG_PRESS_EN
            ,
            .LONG_CYCLES   (LONG_CYCLES)
`endif
        ) u_ch (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (en_i),
            .sw_i   (sw_i[i]),
            .db_o   (db_o[i]),
            .rise_o (rise_o[i]),
            .fall_o (fall_o[i])
`ifdef DEBOUNCER_LONG_PRESS_EN
            ,
            .long_o (long_o[i])
`endif
        );
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: directed scenarios plus random traffic against a timestamp-based reference model.
// Build with DEBOUNCER_LONG_PRESS_EN defined to also exercise the long-press outputs.
module tb_debouncer_multi;

    localparam int N  = 4;
    localparam int SC = 10;
    localparam int SS = 2;
`ifdef DEBOUNCER_LONG_PRESS_EN
    localparam int LC = 40;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         en_i;
    logic [N-1:0] sw_i;
    logic [N-1:0] db_o, rise_o, fall_o, long_w;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk_i = ~clk_i;

    debouncer_multi #(
        .N_CH          (N),
        .STABLE_CYCLES (SC),
        .SYNC_STAGES   (SS)
`ifdef DEBOUNCER_LONG_PRESS_EN
        ,
        .LONG_CYCLES   (LC)
`endif
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .sw_i   (sw_i),
        .db_o   (db_o),
        .rise_o (rise_o),
        .fall_o (fall_o)
`ifdef DEBOUNCER_LONG_PRESS_EN
        ,
        .long_o (long_w)
`endif
    );
`ifndef DEBOUNCER_LONG_PRESS_EN
    assign long_w = '0;
`endif

    // Reference model: the synchronised level is the raw input SS edges earlier. A channel
    // flips when the enabled-edge count has advanced by SC since it last agreed with db.
    logic [N-1:0] hist [SS];
    logic [N-1:0] m_db, m_rise, m_fall, m_long;
    int unsigned  en_tick;
    int unsigned  mark  [N];
    int unsigned  lmark [N];

    task automatic model_step();
        int unsigned e;
        logic        s;
        m_rise = '0;
        m_fall = '0;
        m_long = '0;
        if (rst_i) begin
            for (int k = 0; k < SS; k++) hist[k] = '0;
            m_db    = '0;
            en_tick = 0;
            for (int c = 0; c < N; c++) begin
                mark[c]  = 0;
                lmark[c] = 0;
            end
        end else begin
            e = en_tick + (en_i ? 1 : 0);
            for (int c = 0; c < N; c++) begin
                s = hist[SS-1][c];
`ifdef DEBOUNCER_LONG_PRESS_EN
                if (m_db[c] && en_i && (e - lmark[c] == LC)) m_long[c] = 1'b1;
`endif
                if (s == m_db[c]) begin
                    mark[c] = e;
                end else if (en_i && (e - mark[c] == SC)) begin
                    m_db[c] = s;
                    mark[c] = e;
                    if (s) begin
                        m_rise[c] = 1'b1;
                        lmark[c]  = e;
                    end else begin
                        m_fall[c] = 1'b1;
                    end
                end
            end
            en_tick = e;
            for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = sw_i;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        cyc++;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        int seen = 0;
        logic [N-1:0] rise_at = '0;
        rst_i = 1'b1;
        en_i  = 1'b1;
        sw_i  = 4'hF;
        repeat (2) begin
            tick();
            checks++;
            if ({db_o, rise_o, fall_o, long_w} !== 16'h0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got db=%h rise=%h fall=%h long=%h want all 0",
                         cyc, db_o, rise_o, fall_o, long_w);
            end
        end
        rst_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if ({db_o, rise_o, fall_o, long_w} !== {m_db, m_rise, m_fall, m_long}) begin
                failures++;
                $display("FAIL model_reset cyc=%0d got db=%h r=%h f=%h l=%h exp db=%h r=%h f=%h l=%h",
                         cyc, db_o, rise_o, fall_o, long_w, m_db, m_rise, m_fall, m_long);
            end
            if (db_o == 4'hF && seen == 0) begin
                seen    = k;
                rise_at = rise_o;
            end
        end
        checks++;
        if (seen !== 12) begin
            failures++;
            $display("FAIL reset_latency got %0d cycles want 12", seen);
        end
        checks++;
        if (rise_at !== 4'hF) begin
            failures++;
            $display("FAIL reset_rise got %h want f", rise_at);
        end
    endtask

    task automatic test_clean_press();
        int rc = 0, fc = 0, rat = 0, fat = 0;
        sw_i = 4'h0;
        settle(15);
        sw_i[0] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            if (k == 31) sw_i[0] = 1'b0;
            tick();
            checks++;
            if ({db_o, rise_o, fall_o, long_w} !== {m_db, m_rise, m_fall, m_long}) begin
                failures++;
                $display("FAIL model_press cyc=%0d got db=%h r=%h f=%h l=%h exp db=%h r=%h f=%h l=%h",
                         cyc, db_o, rise_o, fall_o, long_w, m_db, m_rise, m_fall, m_long);
            end
            if (rise_o[0]) begin rc++; rat = k; end
            if (fall_o[0]) begin fc++; fat = k; end
        end
        checks++;
        if (rc !== 1 || rat !== 12) begin
            failures++;
            $display("FAIL press_rise got count=%0d at=%0d want count=1 at=12", rc, rat);
        end
        checks++;
        if (fc !== 1 || fat !== 42) begin
            failures++;
            $display("FAIL press_fall got count=%0d at=%0d want count=1 at=42", fc, fat);
        end
    endtask

    task automatic test_bounce();
        int glitches = 0, rc = 0, rat = 0;
        int hw, lw;
        for (int it = 0; it < 50; it++) begin
            hw = int'($urandom_range(1, 9));
            lw = int'($urandom_range(1, 9));
            for (int p = 0; p < hw + lw; p++) begin
                sw_i[1] = (p < hw);
                tick();
                checks++;
                if ({db_o, rise_o, fall_o, long_w} !== {m_db, m_rise, m_fall, m_long}) begin
                    failures++;
                    $display("FAIL model_bounce cyc=%0d got db=%h r=%h f=%h exp db=%h r=%h f=%h",
                             cyc, db_o, rise_o, fall_o, m_db, m_rise, m_fall);
                end
                if (db_o[1] || rise_o[1] || fall_o[1]) glitches++;
            end
        end
        checks++;
        if (glitches !== 0) begin
            failures++;
            $display("FAIL bounce_reject got %0d cycles with output activity want 0", glitches);
        end
        sw_i[1] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (rise_o[1]) begin rc++; rat = k; end
        end
        checks++;
        if (rc !== 1 || rat !== 12) begin
            failures++;
            $display("FAIL bounce_settle got count=%0d at=%0d want count=1 at=12", rc, rat);
        end
    endtask

    task automatic test_enable();
        int en_cnt, exp_at, chg_at;
        for (int phase = 0; phase < 2; phase++) begin
            en_cnt = 0;
            exp_at = 0;
            chg_at = 0;
            sw_i[2] = (phase == 0);
            for (int k = 1; k <= 80; k++) begin
                en_i = (k % 4 == 0) && !(phase == 1 && k >= 13 && k <= 32);
                tick();
                checks++;
                if ({db_o, rise_o, fall_o, long_w} !== {m_db, m_rise, m_fall, m_long}) begin
                    failures++;
                    $display("FAIL model_enable cyc=%0d got db=%h r=%h f=%h exp db=%h r=%h f=%h",
                             cyc, db_o, rise_o, fall_o, m_db, m_rise, m_fall);
                end
                if (en_i && k >= SS + 1) en_cnt++;
                if (en_cnt == SC && exp_at == 0) exp_at = k;
                if (db_o[2] == (phase == 0) && chg_at == 0) chg_at = k;
            end
            checks++;
            if (chg_at !== exp_at) begin
                failures++;
                $display("FAIL enable_phase%0d got change at %0d want %0d", phase, chg_at, exp_at);
            end
        end
        en_i = 1'b1;
    endtask

    task automatic test_simultaneous();
        int r2 = 0, r3 = 0;
        sw_i[3:2] = 2'b11;
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if ({db_o, rise_o, fall_o, long_w} !== {m_db, m_rise, m_fall, m_long}) begin
                failures++;
                $display("FAIL model_simul cyc=%0d got db=%h r=%h f=%h exp db=%h r=%h f=%h",
                         cyc, db_o, rise_o, fall_o, m_db, m_rise, m_fall);
            end
            if (rise_o[2]) r2 = k;
            if (rise_o[3]) r3 = k;
        end
        checks++;
        if (r2 !== 12 || r3 !== 12) begin
            failures++;
            $display("FAIL simul_rise got ch2 at %0d ch3 at %0d want both 12", r2, r3);
        end
    endtask

    task automatic test_reset_mid();
        int rc = 0, rat = 0;
        sw_i[0] = 1'b1;
        settle(9);
        rst_i = 1'b1;
        tick();
        checks++;
        if ({db_o, rise_o, fall_o} !== 12'h0) begin
            failures++;
            $display("FAIL reset_mid_clear got db=%h rise=%h fall=%h want 0", db_o, rise_o, fall_o);
        end
        rst_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if ({db_o, rise_o, fall_o, long_w} !== {m_db, m_rise, m_fall, m_long}) begin
                failures++;
                $display("FAIL model_rstmid cyc=%0d got db=%h r=%h f=%h exp db=%h r=%h f=%h",
                         cyc, db_o, rise_o, fall_o, m_db, m_rise, m_fall);
            end
            if (rise_o[0]) begin rc++; rat = k; end
        end
        checks++;
        if (rc !== 1 || rat !== 12) begin
            failures++;
            $display("FAIL reset_mid_latency got count=%0d at=%0d want count=1 at=12", rc, rat);
        end
    endtask

`ifdef DEBOUNCER_LONG_PRESS_EN
    task automatic test_long_press();
        int rat = 0, lat = 0, lc_cnt = 0;
        sw_i[0] = 1'b0;
        settle(15);
        sw_i[0] = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            checks++;
            if ({db_o, rise_o, fall_o, long_w} !== {m_db, m_rise, m_fall, m_long}) begin
                failures++;
                $display("FAIL model_long cyc=%0d got db=%h r=%h f=%h l=%h exp db=%h r=%h f=%h l=%h",
                         cyc, db_o, rise_o, fall_o, long_w, m_db, m_rise, m_fall, m_long);
            end
            if (rise_o[0]) rat = k;
            if (long_w[0]) begin lc_cnt++; lat = k; end
        end
        checks++;
        if (lc_cnt !== 1 || lat - rat !== LC) begin
            failures++;
            $display("FAIL long_pulse got count=%0d offset=%0d want count=1 offset=%0d",
                     lc_cnt, lat - rat, LC);
        end
    endtask
`endif

    task automatic test_random();
        int hold [N];
        for (int c = 0; c < N; c++) hold[c] = 0;
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    sw_i[c] = 1'($urandom_range(0, 1));
                    hold[c] = int'($urandom_range(1, 14));
                end
                hold[c]--;
            end
            en_i  = ($urandom_range(0, 9) != 0);
            rst_i = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if ({db_o, rise_o, fall_o, long_w} !== {m_db, m_rise, m_fall, m_long}) begin
                failures++;
                $display("FAIL model_random cyc=%0d got db=%h r=%h f=%h l=%h exp db=%h r=%h f=%h l=%h",
                         cyc, db_o, rise_o, fall_o, long_w, m_db, m_rise, m_fall, m_long);
            end
        end
        rst_i = 1'b0;
        en_i  = 1'b1;
    endtask

    initial begin
        rst_i = 1'b1;
        en_i  = 1'b1;
        sw_i  = 4'hF;
        test_reset();
        test_clean_press();
        test_bounce();
        test_enable();
        test_simultaneous();
        test_reset_mid();
`ifdef DEBOUNCER_LONG_PRESS_EN
        test_long_press();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
